// File: rtl/fft_pkg.sv
// Shared FFT constants: default sample width, rounding constant and saturation bounds.
package fft_pkg;

  localparam int unsigned FFT_WIDTH = 16;

  // Half-LSB of a Q1.(w-1) product scaled back to w bits
  function automatic longint fft_rnd(input int unsigned w);
    return longint'(1) << (w - 1);
  endfunction

  function automatic longint fft_sat_max(input int unsigned w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint fft_sat_min(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/cmul_conj.sv
// Registered conjugate complex multiply: p = d * conj(w), full precision.
module cmul_conj
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = FFT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH:0]       dr,
  input  logic [WIDTH:0]       di,
  input  logic [WIDTH-1:0]     wr,
  input  logic [WIDTH-1:0]     wi,
  output logic [2*WIDTH+1:0]   pr,
  output logic [2*WIDTH+1:0]   pi
);

  localparam int unsigned PW = 2 * WIDTH + 2;

  logic signed [PW-1:0] drx, dix, wrx, wix;

  assign drx = PW'($signed(dr));
  assign dix = PW'($signed(di));
  assign wrx = PW'($signed(wr));
  assign wix = PW'($signed(wi));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr <= '0;
      pi <= '0;
    end else if (en) begin
      pr <= drx * wrx + dix * wix;
      pi <= dix * wrx - drx * wix;
    end
  end

endmodule

// File: rtl/ibutterfly.sv
// Inverse-direction DIF butterfly, 3-stage pipeline with a single global enable.
// Define IBF_SATURATE_EN to clamp the z outputs and enable the sticky ovf flag.
module ibutterfly
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = FFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_real,
  input  logic [WIDTH-1:0] a_imag,
  input  logic [WIDTH-1:0] b_real,
  input  logic [WIDTH-1:0] b_imag,
  input  logic [WIDTH-1:0] twiddle_real,
  input  logic [WIDTH-1:0] twiddle_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_real,
  output logic [WIDTH-1:0] y_imag,
  output logic [WIDTH-1:0] z_real,
  output logic [WIDTH-1:0] z_imag,
  input  logic             ovf_clr,
  output logic             ovf
);

  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH + 2;
  localparam logic signed [PW-1:0] RND = PW'(fft_rnd(WIDTH));

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // S1: lossless sum and difference
  logic                 v1;
  logic signed [SW-1:0] sr1, si1, dr1, di1;
  logic [WIDTH-1:0]     wr1, wi1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      sr1 <= '0;
      si1 <= '0;
      dr1 <= '0;
      di1 <= '0;
      wr1 <= '0;
      wi1 <= '0;
    end else if (en) begin
      v1  <= in_valid;
      sr1 <= SW'($signed(a_real)) + SW'($signed(b_real));
      si1 <= SW'($signed(a_imag)) + SW'($signed(b_imag));
      dr1 <= SW'($signed(a_real)) - SW'($signed(b_real));
      di1 <= SW'($signed(a_imag)) - SW'($signed(b_imag));
      wr1 <= twiddle_real;
      wi1 <= twiddle_imag;
    end
  end

  // S2: rounded halving of the sum, full-precision conjugate products
  logic             v2;
  logic [WIDTH-1:0] yr2, yi2;
  logic [PW-1:0]    pr2, pi2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      yr2 <= '0;
      yi2 <= '0;
    end else if (en) begin
      v2  <= v1;
      yr2 <= WIDTH'((sr1 + SW'(1)) >>> 1);
      yi2 <= WIDTH'((si1 + SW'(1)) >>> 1);
    end
  end

  cmul_conj #(.WIDTH(WIDTH)) u_cmul (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .dr  (dr1),
    .di  (di1),
    .wr  (wr1),
    .wi  (wi1),
    .pr  (pr2),
    .pi  (pi2)
  );

  // S3: scale by 2^-WIDTH with round-half-up, then limit to WIDTH bits
  logic [WIDTH-1:0] zr3, zi3;

`ifdef IBF_SATURATE_EN
  localparam logic signed [PW-1:0] ZMAX = PW'(fft_sat_max(WIDTH));
  localparam logic signed [PW-1:0] ZMIN = PW'(fft_sat_min(WIDTH));

  logic signed [PW-1:0] zr_s, zi_s;
  logic                 sat_r, sat_i;

  always_comb begin
    zr_s  = ($signed(pr2) + RND) >>> WIDTH;
    zi_s  = ($signed(pi2) + RND) >>> WIDTH;
    sat_r = (zr_s > ZMAX) || (zr_s < ZMIN);
    sat_i = (zi_s > ZMAX) || (zi_s < ZMIN);
    if (zr_s > ZMAX)      zr3 = WIDTH'(ZMAX);
    else if (zr_s < ZMIN) zr3 = WIDTH'(ZMIN);
    else                  zr3 = zr_s[WIDTH-1:0];
    if (zi_s > ZMAX)      zi3 = WIDTH'(ZMAX);
    else if (zi_s < ZMIN) zi3 = WIDTH'(ZMIN);
    else                  zi3 = zi_s[WIDTH-1:0];
  end

  // Only loads carrying a valid result may raise ovf; set wins over clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (en && v2 && (sat_r || sat_i)) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;

  always_comb begin
    zr3 = WIDTH'(($signed(pr2) + RND) >>> WIDTH);
    zi3 = WIDTH'(($signed(pi2) + RND) >>> WIDTH);
  end

  assign ovf            = 1'b0;
  assign unused_ovf_clr = ovf_clr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y_real    <= '0;
      y_imag    <= '0;
      z_real    <= '0;
      z_imag    <= '0;
    end else if (en) begin
      out_valid <= v2;
      y_real    <= yr2;
      y_imag    <= yi2;
      z_real    <= zr3;
      z_imag    <= zi3;
    end
  end

endmodule

// File: tb/tb_ibutterfly.sv
// Scoreboard bench for ibutterfly; expected results come from plain integer arithmetic.
module tb_ibutterfly;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_real, a_imag, b_real, b_imag, twiddle_real, twiddle_imag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y_real, y_imag, z_real, z_imag;
  logic          ovf_clr;
  logic          ovf;

  ibutterfly #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_real       (a_real),
    .a_imag       (a_imag),
    .b_real       (b_real),
    .b_imag       (b_imag),
    .twiddle_real (twiddle_real),
    .twiddle_imag (twiddle_imag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .y_real       (y_real),
    .y_imag       (y_imag),
    .z_real       (z_real),
    .z_imag       (z_imag),
    .ovf_clr      (ovf_clr),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] yr, yi, zr, zi;
    bit          sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  bit   exp_ovf = 1'b0;
  bit   rand_rdy = 1'b0;

  function automatic logic signed [31:0] sx(input logic [15:0] v);
    return 32'($signed(v));
  endfunction

  function automatic longint lx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic bit out_of_range(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic logic [15:0] lim(input longint v);
`ifdef IBF_SATURATE_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return 16'(v);
  endfunction

  // y = (a+b)/2 and z = (a-b)*conj(w)/2 with round-half-up scaling
  function automatic exp_t model(input logic [15:0] ar, ai, br, bi, wr, wi);
    exp_t   e;
    longint sr, si, dr, di, pr, pi, zr, zi;
    sr = lx(ar) + lx(br);
    si = lx(ai) + lx(bi);
    dr = lx(ar) - lx(br);
    di = lx(ai) - lx(bi);
    pr = dr * lx(wr) + di * lx(wi);
    pi = di * lx(wr) - dr * lx(wi);
    zr = (pr + 32768) >>> 16;
    zi = (pi + 32768) >>> 16;
    e.yr = 16'((sr + 1) >>> 1);
    e.yi = 16'((si + 1) >>> 1);
    e.zr = lim(zr);
    e.zi = lim(zi);
    e.sat = 1'b0;
`ifdef IBF_SATURATE_EN
    e.sat = out_of_range(zr) || out_of_range(zi);
`endif
    return e;
  endfunction

  function automatic logic [15:0] rv();
    int k = int'($urandom_range(0, 9));
    if (k == 0) return 16'h7FFF;
    if (k == 1) return 16'h8000;
    return 16'($urandom);
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic zero_inputs();
    in_valid = 1'b0;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    twiddle_real = '0; twiddle_imag = '0;
  endtask

  task automatic idle();
    zero_inputs();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the edge that took the transfer
  task automatic send(input logic [15:0] ar, ai, br, bi, wr, wi);
    int n = 0;
    in_valid = 1'b1;
    a_real = ar; a_imag = ai; b_real = br; b_imag = bi;
    twiddle_real = wr; twiddle_imag = wi;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end else begin
      sb.push_back(model(ar, ai, br, bi, wr, wi));
    end
    @(posedge clk); #1;
    zero_inputs();
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      idle();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 99) < 70);
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output y_real=%0d required=none", sx(y_real));
      end else begin
        mon_e = sb.pop_front();
        popped++;
        chk("y_real", sx(y_real), sx(mon_e.yr));
        chk("y_imag", sx(y_imag), sx(mon_e.yi));
        chk("z_real", sx(z_real), sx(mon_e.zr));
        chk("z_imag", sx(z_imag), sx(mon_e.zi));
        if (mon_e.sat) exp_ovf = 1'b1;
        chk("ovf_sticky", 32'(ovf), 32'(exp_ovf));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int          lat;
    int          p0;
    int          nval;
    logic [15:0] snap [4];

    rst = 1'b1;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    zero_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_y_real", sx(y_real), 0);
    chk("rst_z_imag", sx(z_imag), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(in_ready), 1);

    send(16'd1000, 16'd200, 16'd600, 16'(-200), 16'd32767, 16'd0);
    wait_out(lat);
    chk("latency", lat, 3);
    chk("v1_y_real", sx(y_real), 800);
    chk("v1_y_imag", sx(y_imag), 0);
    chk("v1_z_real", sx(z_real), 200);
    chk("v1_z_imag", sx(z_imag), 200);
    drain();

    send(16'd0, 16'd0, 16'(-1000), 16'd0, 16'd0, 16'd32767);
    wait_out(lat);
    chk("v2_y_real", sx(y_real), -500);
    chk("v2_y_imag", sx(y_imag), 0);
    chk("v2_z_real", sx(z_real), 0);
    chk("v2_z_imag", sx(z_imag), -500);
    drain();

    send(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'd23170, 16'd23170);
    wait_out(lat);
    chk("v3_y_real", sx(y_real), 0);
    chk("v3_y_imag", sx(y_imag), 0);
    chk("v3_z_imag", sx(z_imag), 0);
`ifdef IBF_SATURATE_EN
    chk("v3_z_real", sx(z_real), 32767);
    chk("v3_ovf", 32'(ovf), 1);
`else
    chk("v3_ovf", 32'(ovf), 0);
`endif
    drain();

    ovf_clr = 1'b1;
    idle();
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(ovf), 0);
    @(posedge clk); #1;

    ovf_clr = 1'b1;
    send(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'd23170, 16'd23170);
    wait_out(lat);
`ifdef IBF_SATURATE_EN
    chk("ovf_set_beats_clr", 32'(ovf), 1);
`else
    chk("ovf_set_beats_clr", 32'(ovf), 0);
`endif
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared_again", 32'(ovf), 0);
    @(posedge clk); #1;
    drain();

    p0 = popped;
    fork
      begin
        for (int i = 0; i < 4; i++) send(rv(), rv(), rv(), rv(), rv(), rv());
      end
      begin
        int n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        out_ready = 1'b0;
        chk("stall_seen_valid", 32'(out_valid), 1);
        snap[0] = y_real; snap[1] = y_imag; snap[2] = z_real; snap[3] = z_imag;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 0);
          chk("stall_out_valid", 32'(out_valid), 1);
          chk("stall_y_real", sx(y_real), sx(snap[0]));
          chk("stall_y_imag", sx(y_imag), sx(snap[1]));
          chk("stall_z_real", sx(z_real), sx(snap[2]));
          chk("stall_z_imag", sx(z_imag), sx(snap[3]));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", popped - p0, 4);

    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send(rv(), rv(), rv(), rv(), rv(), rv());
    end
    rand_rdy = 1'b0;
    idle();
    out_ready = 1'b1;
    drain();

    send(16'd1000, 16'd200, 16'd600, 16'(-200), 16'd32767, 16'd0);
    send(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'd23170, 16'd23170);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    sb.delete();
    exp_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    nval = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) nval++;
    end
    chk("midrst_no_stale", nval, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
